// File: rtl/pkt_buf_ctrl_if.sv
// Framed input word stream (sop/eop) feeding the packet buffer controller.
// There is no backpressure, so the stream carries no ready signal.
interface pkt_buf_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_sop, output in_eop, output in_data);
  modport slave  (input  in_valid, input  in_sop, input  in_eop, input  in_data);
endinterface

// File: rtl/pkt_buf_ctrl.sv
// Write/commit/read pointer controller for the packet buffer RAM: packets become
// visible to the reader only once their eop is written; overflowing packets are rewound.
module pkt_buf_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16384,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  pkt_buf_ctrl_clk,
  input  logic                  pkt_buf_ctrl_rst,
  input  logic                  pkt_buf_ctrl_sw_rst,
  pkt_buf_ctrl_if.slave         in_if,
  input  logic                  rd_req_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH:0]   rd_addr_o,
  output logic                  buffer_full,
  output logic                  buffer_empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  err_nosop
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_depth_check
    $error("pkt_buf_ctrl: DEPTH must equal 2**ADDR_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]     commit_ptr, commit_nxt;
  logic [PTR_W-1:0]     rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]     wr_addr;
  logic                 wr_en;
  logic                 rd_en;
  logic                 nosop_nxt;
  logic [1:0]           pkt_add;
  logic [1:0]           drop_add;

  // Saturating add for the statistics counters; n is 0..2 per cycle.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0] n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, n};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // Flags come from registered pointers only, so a read never frees space for
  // a write in the same cycle. Uncommitted words count toward full only.
  assign buffer_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign buffer_empty = (commit_ptr == rd_ptr);
  assign fill_level   = commit_ptr - rd_ptr;

  assign wr_en_o   = wr_en;
  assign wr_addr_o = wr_addr;
  assign wr_data_o = in_if.in_data;

  assign rd_en      = rd_req_i && !buffer_empty;
  assign rd_en_o    = rd_en;
  assign rd_addr_o  = rd_ptr;
  assign rd_ptr_nxt = rd_en ? (rd_ptr + PTR_ONE) : rd_ptr;

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    wr_addr    = wr_ptr;
    wr_en      = 1'b0;
    pkt_add    = 2'd0;
    drop_add   = 2'd0;
    nosop_nxt  = 1'b0;
    if (in_if.in_valid) begin
      unique case (state)
        IDLE, DROP: begin
          if (in_if.in_sop) begin
            if (!buffer_full) begin
              wr_en      = 1'b1;
              wr_ptr_nxt = wr_ptr + PTR_ONE;
              if (in_if.in_eop) begin
                commit_nxt = wr_ptr + PTR_ONE;
                pkt_add    = 2'd1;
                state_nxt  = IDLE;
              end else begin
                state_nxt  = WRITE;
              end
            end else begin
              drop_add  = 2'd1;
              state_nxt = in_if.in_eop ? IDLE : DROP;
            end
          end else if (state == IDLE) begin
            nosop_nxt = 1'b1;
          end else if (in_if.in_eop) begin
            state_nxt = IDLE;
          end
        end
        WRITE: begin
          if (in_if.in_sop) begin
            // Truncated packet: abandon it and restart the new one at commit_ptr.
            wr_addr = commit_ptr;
            if (!buffer_full) begin
              drop_add   = 2'd1;
              wr_en      = 1'b1;
              wr_ptr_nxt = commit_ptr + PTR_ONE;
              if (in_if.in_eop) begin
                commit_nxt = commit_ptr + PTR_ONE;
                pkt_add    = 2'd1;
                state_nxt  = IDLE;
              end
            end else begin
              // No room this cycle: the new packet is lost along with the old one.
              drop_add   = 2'd2;
              wr_ptr_nxt = commit_ptr;
              state_nxt  = in_if.in_eop ? IDLE : DROP;
            end
          end else if (!buffer_full) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (in_if.in_eop) begin
              commit_nxt = wr_ptr + PTR_ONE;
              pkt_add    = 2'd1;
              state_nxt  = IDLE;
            end
          end else begin
            wr_ptr_nxt = commit_ptr;
            drop_add   = 2'd1;
            state_nxt  = in_if.in_eop ? IDLE : DROP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Soft clear has the same effect as reset and wins over every other event.
  always_ff @(posedge pkt_buf_ctrl_clk or posedge pkt_buf_ctrl_rst) begin
    if (pkt_buf_ctrl_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      err_nosop  <= 1'b0;
    end else if (pkt_buf_ctrl_sw_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      err_nosop  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      rd_ptr     <= rd_ptr_nxt;
      pkt_cnt    <= sat_add(pkt_cnt, pkt_add);
      drop_cnt   <= sat_add(drop_cnt, drop_add);
      err_nosop  <= nosop_nxt;
    end
  end

endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// Scoreboard bench for pkt_buf_ctrl with an 8-word buffer and a behavioural RAM.
module tb_pkt_buf_ctrl;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int CW = 16;

  typedef struct packed {
    logic [AW:0]   addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sw_rst = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_en_o, rd_en_o, buffer_full, buffer_empty, err_nosop;
  logic [AW:0]   wr_addr_o, rd_addr_o, fill_level;
  logic [DW-1:0] wr_data_o;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  pkt_buf_ctrl_if #(.DATA_WIDTH(DW)) in_if ();

  pkt_buf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(8), .CNT_WIDTH(CW)) dut (
    .pkt_buf_ctrl_clk   (clk),
    .pkt_buf_ctrl_rst   (rst),
    .pkt_buf_ctrl_sw_rst(sw_rst),
    .in_if              (in_if.slave),
    .rd_req_i           (rd_req),
    .wr_en_o            (wr_en_o),
    .wr_addr_o          (wr_addr_o),
    .wr_data_o          (wr_data_o),
    .rd_en_o            (rd_en_o),
    .rd_addr_o          (rd_addr_o),
    .buffer_full        (buffer_full),
    .buffer_empty       (buffer_empty),
    .fill_level         (fill_level),
    .pkt_cnt            (pkt_cnt),
    .drop_cnt           (drop_cnt),
    .err_nosop          (err_nosop)
  );

  always #5 clk = ~clk;

  int      n_chk = 0;
  int      n_err = 0;
  int      rd_en_cnt = 0;
  ent_t    wr_q[$];
  ent_t    rd_q[$];
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rd_data;
  logic          rd_pend = 1'b0;
  logic [DW-1:0] rd_exp_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // RAM model driven by the controller's ports
  always @(posedge clk) begin
    if (wr_en_o) mem[wr_addr_o[AW-1:0]] <= wr_data_o;
    if (rd_en_o) rd_data <= mem[rd_addr_o[AW-1:0]];
  end

  always @(negedge clk) begin
    ent_t e;
    if (rd_pend) begin
      chk("rd_data", rd_data, rd_exp_data);
      rd_pend = 1'b0;
    end
    if (wr_en_o) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'(wr_addr_o), 32'hFFFF_FFFF);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        chk("wr_data", wr_data_o, e.data);
      end
    end
    if (rd_en_o) begin
      rd_en_cnt++;
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_addr_o), 32'hFFFF_FFFF);
      else begin
        e = rd_q.pop_front();
        chk("rd_addr", 32'(rd_addr_o), 32'(e.addr));
        rd_exp_data = e.data;
        rd_pend     = 1'b1;
      end
    end
  end

  task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d,
                      input bit wr, input logic [AW:0] a);
    ent_t e;
    @(posedge clk); #1;
    in_if.in_valid = 1'b1;
    in_if.in_sop   = sop;
    in_if.in_eop   = eop;
    in_if.in_data  = d;
    if (wr) begin
      e.addr = a;
      e.data = d;
      wr_q.push_back(e);
    end
  endtask

  task automatic push_rd(input logic [AW:0] a, input logic [DW-1:0] d);
    ent_t e;
    e.addr = a;
    e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
    in_if.in_sop   = 1'b0;
    in_if.in_eop   = 1'b0;
  endtask

  task automatic rd_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_req = 1'b1;
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  // Sends an n-word packet starting at address a0; all words are expected to commit.
  task automatic send_pkt(input int n, input logic [DW-1:0] base, input logic [AW:0] a0);
    logic [AW:0] a;
    a = a0;
    for (int i = 0; i < n; i++) begin
      send(i == 0, i == n - 1, base + DW'(i), 1'b1, a);
      push_rd(a, base + DW'(i));
      a = a + 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    in_if.in_valid = 1'b0;
    in_if.in_sop   = 1'b0;
    in_if.in_eop   = 1'b0;
    in_if.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(buffer_empty), 32'd1);
    chk("rst_full", 32'(buffer_full), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_rd_en", 32'(rd_en_o), 32'd0);
    chk("rst_cnts", {pkt_cnt, drop_cnt}, 32'd0);
    chk("rst_err", 32'(err_nosop), 32'd0);

    // 3-word packet A at 0..2
    send_pkt(3, 32'hA000_0001, 4'd0);
    @(negedge clk);
    chk("a_empty_at_eop", 32'(buffer_empty), 32'd1);
    idle();
    @(negedge clk);
    chk("a_empty_after", 32'(buffer_empty), 32'd0);
    chk("a_fill", 32'(fill_level), 32'd3);
    chk("a_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // four requests, only three served
    c0 = rd_en_cnt;
    rd_burst(4);
    chk("a_rd_en_cycles", 32'(rd_en_cnt - c0), 32'd3);
    chk("a_drained_empty", 32'(buffer_empty), 32'd1);

    // clean pointers, then 6-word B and 5-word C that overflows at its 3rd word
    @(posedge clk); #1 sw_rst = 1'b1;
    @(posedge clk); #1 sw_rst = 1'b0;
    send_pkt(6, 32'hB000_0000, 4'd0);
    send(1'b1, 1'b0, 32'hC000_0000, 1'b1, 4'd6);
    send(1'b0, 1'b0, 32'hC000_0001, 1'b1, 4'd7);
    send(1'b0, 1'b0, 32'hC000_0002, 1'b0, 4'd0);
    @(negedge clk);
    chk("c_full", 32'(buffer_full), 32'd1);
    chk("c_no_write_full", 32'(wr_en_o), 32'd0);
    send(1'b0, 1'b0, 32'hC000_0003, 1'b0, 4'd0);
    send(1'b0, 1'b1, 32'hC000_0004, 1'b0, 4'd0);
    idle();
    @(negedge clk);
    chk("c_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("c_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("c_fill", 32'(fill_level), 32'd6);
    chk("c_wr_rewind", 32'(wr_addr_o), 32'd6);
    chk("c_full_cleared", 32'(buffer_full), 32'd0);
    chk("c_no_err", 32'(err_nosop), 32'd0);
    rd_burst(6);
    chk("b_drained_empty", 32'(buffer_empty), 32'd1);

    // truncated X, replaced by Y at the old commit point
    send(1'b1, 1'b0, 32'hD000_0000, 1'b1, 4'd6);
    send(1'b0, 1'b0, 32'hD000_0001, 1'b1, 4'd7);
    send(1'b1, 1'b0, 32'hE000_0000, 1'b1, 4'd6);
    push_rd(4'd6, 32'hE000_0000);
    send(1'b0, 1'b1, 32'hE000_0001, 1'b1, 4'd7);
    push_rd(4'd7, 32'hE000_0001);
    idle();
    @(negedge clk);
    chk("y_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("y_pkt_cnt", 32'(pkt_cnt), 32'd2);
    chk("y_fill", 32'(fill_level), 32'd2);
    rd_burst(2);

    // word outside a packet
    send(1'b0, 1'b0, 32'h5555_5555, 1'b0, 4'd0);
    @(negedge clk);
    chk("nosop_no_write", 32'(wr_en_o), 32'd0);
    chk("nosop_err_early", 32'(err_nosop), 32'd0);
    idle();
    @(negedge clk);
    chk("nosop_err_pulse", 32'(err_nosop), 32'd1);
    idle();
    @(negedge clk);
    chk("nosop_err_clear", 32'(err_nosop), 32'd0);

    // D brings wr_ptr to 14, then E straddles the wrap at 14,15,0,1
    send_pkt(6, 32'h1111_0000, 4'd8);
    idle();
    rd_burst(6);
    send_pkt(4, 32'h2222_0000, 4'd14);
    idle();
    @(negedge clk);
    chk("wrap_wr_ptr", 32'(wr_addr_o), 32'd2);
    chk("wrap_fill", 32'(fill_level), 32'd4);
    rd_burst(4);
    chk("wrap_empty", 32'(buffer_empty), 32'd1);

    // soft clear mid-packet with 5 committed words
    send_pkt(5, 32'h3333_0000, 4'd2);
    send(1'b1, 1'b0, 32'h4444_0000, 1'b1, 4'd7);
    send(1'b0, 1'b0, 32'h4444_0001, 1'b1, 4'd8);
    @(negedge clk);
    chk("sw_fill_before", 32'(fill_level), 32'd5);
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
    in_if.in_sop   = 1'b0;
    in_if.in_eop   = 1'b0;
    sw_rst = 1'b1;
    @(posedge clk); #1 sw_rst = 1'b0;
    @(negedge clk);
    rd_q.delete();
    chk("sw_wr_ptr", 32'(wr_addr_o), 32'd0);
    chk("sw_rd_ptr", 32'(rd_addr_o), 32'd0);
    chk("sw_empty", 32'(buffer_empty), 32'd1);
    chk("sw_fill", 32'(fill_level), 32'd0);
    chk("sw_cnts", {pkt_cnt, drop_cnt}, 32'd0);
    c0 = rd_en_cnt;
    rd_burst(1);
    chk("sw_rd_ignored", 32'(rd_en_cnt - c0), 32'd0);
    send(1'b0, 1'b0, 32'h4444_0002, 1'b0, 4'd0);
    idle();
    @(negedge clk);
    chk("sw_nosop_err", 32'(err_nosop), 32'd1);

    repeat (2) @(negedge clk);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_buf_ctrl.md
Name: pkt_buf_ctrl

Overview:
- Pointer and flag controller that sits directly upstream of the packet buffer RAM and drives its write port, read port and full/empty inputs.
- Accepts a framed word stream (sop/eop), writes words into the buffer and commits a packet to the reader only after its eop is written.
- Drops whole packets that overflow the buffer and rewinds the write pointer so no partial packet is ever visible to the reader.
- Also owns the read pointer, serving read requests from the downstream parser.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 14, buffer address bits; pointers are ADDR_WIDTH+1 bits (extra MSB is the wrap bit).
- DEPTH, 16384, buffer words; must equal 2**ADDR_WIDTH.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- pkt_buf_ctrl_clk  in  1  clock
- pkt_buf_ctrl_rst  in  1  asynchronous active-high reset
- pkt_buf_ctrl_sw_rst  in  1  synchronous active-high soft clear; same effect as reset, applied at the clock edge
- in_valid  in  1  input word valid; no backpressure
- in_sop  in  1  first word of packet, qualified by in_valid
- in_eop  in  1  last word of packet, qualified by in_valid
- in_data  in  DATA_WIDTH  input word
- rd_req_i  in  1  downstream requests the next word
- wr_en_o  out  1  buffer write enable
- wr_addr_o  out  ADDR_WIDTH+1  write pointer
- wr_data_o  out  DATA_WIDTH  equals in_data
- rd_en_o  out  1  buffer read enable
- rd_addr_o  out  ADDR_WIDTH+1  read pointer
- buffer_full  out  1  no free word
- buffer_empty  out  1  no committed word to read
- fill_level  out  ADDR_WIDTH+1  committed words available (commit_ptr - rd_ptr)
- pkt_cnt  out  CNT_WIDTH  packets committed; saturates
- drop_cnt  out  CNT_WIDTH  packets dropped; saturates
- err_nosop  out  1  one-cycle pulse for a word received outside a packet

Behaviour:
- Registers: wr_ptr, commit_ptr, rd_ptr (all ADDR_WIDTH+1 bits), state, counters.
- Reset or sw_rst: all pointers 0, state IDLE, counters 0, err_nosop 0. Resulting outputs: buffer_empty=1, buffer_full=0, fill_level=0, wr_en_o=0, rd_en_o=0. sw_rst takes priority over all other events in that cycle.
- Flags (combinational from registers):
  - buffer_full = (wr_ptr[MSB] != rd_ptr[MSB]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]).
  - buffer_empty = (commit_ptr == rd_ptr).
  - Uncommitted words count toward full but never toward empty or fill_level.
- Write port: combinational and same-cycle. wr_en_o = in_valid && accept && !buffer_full; wr_addr_o = wr_ptr (or commit_ptr on the rewind cycle, see WRITE); wr_data_o = in_data. The RAM captures on the same edge.
- FSM states: IDLE, WRITE, DROP.
- IDLE:
  - in_valid && !in_sop: word ignored, err_nosop pulses next cycle.
  - sop && !full: word written, wr_ptr++. If in_eop is also set, commit_ptr <= wr_ptr+1, pkt_cnt++, stay IDLE; otherwise go to WRITE.
  - sop && full: drop_cnt++. Go to DROP unless in_eop is also set.
- WRITE:
  - Data word && !full: write, wr_ptr++. On eop: commit_ptr <= new wr_ptr, pkt_cnt++, go to IDLE.
  - Data word && full: wr_ptr <= commit_ptr, drop_cnt++. Go to DROP, or to IDLE if the word is an eop.
  - in_sop in WRITE (truncated packet): previous packet aborted, drop_cnt++. The new word is written at commit_ptr and wr_ptr <= commit_ptr+1 (wr_addr_o = commit_ptr that cycle). Remain in WRITE, or commit and go to IDLE if in_eop is also set.
- DROP: words discarded. Go to IDLE on the eop word. sop in DROP is handled as in IDLE.
- Read side: rd_en_o = rd_req_i && !buffer_empty; rd_addr_o = rd_ptr; rd_ptr++ on rd_en_o. RAM data appears one cycle after rd_en_o. rd_req_i while empty is ignored.
- Simultaneous read and write:
  - Both pointers update in the same cycle.
  - Full is evaluated on registered pointers, so a read does not unblock a write in the same cycle.
  - A commit and a read in the same cycle give fill_level = old + committed - 1.
- Pointer wrap: natural modulo 2**(ADDR_WIDTH+1) increment. A packet may straddle the wrap point.
- A packet longer than DEPTH always ends in DROP.
- Reset mid-packet: partial packet lost, counters cleared. Subsequent non-sop words raise err_nosop.

Test Plan (ADDR_WIDTH=3, DEPTH=8):
- Reset, then a 3-word packet A1..A3 (sop on A1, eop on A3) -> wr_addr 0,1,2; buffer_empty falls the cycle after A3; fill_level=3; pkt_cnt=1.
- Assert rd_req_i for 4 cycles -> rd_en_o for 3 cycles, rd_addr 0,1,2; buffer_empty=1 afterwards; 4th request ignored.
- Write a 6-word packet then a 5-word packet with no reads -> second packet hits full at its 3rd word; wr_ptr rewinds to 6; drop_cnt=1; pkt_cnt unchanged; fill_level=6.
- sop, 2 words, then a new sop without eop -> drop_cnt+1; new packet starts at the old commit_ptr; only the new packet becomes readable.
- Word without sop in IDLE -> no write, err_nosop pulses for 1 cycle.
- Fill to wr_ptr=14, drain, then a 4-word packet -> addresses 14,15,0,1 (MSB wraps); data reads back in order.
- Assert sw_rst mid-packet with fill_level=5 -> next cycle all pointers 0, buffer_empty=1, counters 0.
